// File: rtl/xillybus_stream_packer.sv
// Byte-to-word loopback stage: packs the Xillybus write_8 byte stream into 32-bit words served on read_32.
// Define XILLY_PACKER_BYTE_SWAP_EN for big-endian packing (first byte in bits [31:24]).
module xillybus_stream_packer #(
  parameter int         DEPTH_LOG2 = 4,
  parameter logic [7:0] PAD_BYTE   = 8'h00
) (
  input  logic                  bus_clk,
  input  logic                  bus_rst_n,
  input  logic                  user_w_write_8_wren,
  input  logic [7:0]            user_w_write_8_data,
  output logic                  user_w_write_8_full,
  input  logic                  user_w_write_8_open,
  input  logic                  user_r_read_32_rden,
  output logic [31:0]           user_r_read_32_data,
  output logic                  user_r_read_32_empty,
  output logic                  user_r_read_32_eof,
  input  logic                  user_r_read_32_open,
  output logic [DEPTH_LOG2:0]   fill_level
);

  localparam int                DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FILL_MAX = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, PACK, FLUSH, DONE} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic                  r_open_d;
  logic                  r_rd_open_d;
  logic [1:0]            r_byte_idx;
  logic [31:0]           r_word;
  logic [31:0]           r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_fill;
  logic [31:0]           r_rdata;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_accept;
  logic                  w_flush_push;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_wr_rise;
  logic                  w_wr_fall;
  logic                  w_rd_fall;
  logic [31:0]           w_push_word;

  // Lane k of a word: bits [8k+7:8k] little-endian, [31-8k:24-8k] when byte-swapped.
  function automatic logic [31:0] put_lane(input logic [31:0] word, input logic [1:0] k,
                                           input logic [7:0] b);
    logic [31:0] w;
    w = word;
`ifdef XILLY_PACKER_BYTE_SWAP_EN
    w[8*(3-int'(k)) +: 8] = b;
`else
    w[8*int'(k) +: 8] = b;
`endif
    return w;
  endfunction

  function automatic logic [31:0] pad_word(input logic [31:0] word, input logic [1:0] n);
    logic [31:0] w;
    w = word;
    for (int k = 0; k < 4; k++) begin
      if (k >= int'(n)) w = put_lane(w, 2'(k), PAD_BYTE);
    end
    return w;
  endfunction

  assign w_full       = (r_fill == FILL_MAX) || (r_state == FLUSH);
  assign w_empty      = (r_fill == '0);
  assign w_accept     = user_w_write_8_wren && !w_full && (r_state == PACK) && user_w_write_8_open;
  assign w_flush_push = (r_state == FLUSH) && (r_fill != FILL_MAX);
  assign w_push       = (w_accept && (r_byte_idx == 2'd3)) || w_flush_push;
  assign w_pop        = user_r_read_32_rden && !w_empty;
  assign w_wr_rise    = user_w_write_8_open && !r_open_d;
  assign w_wr_fall    = !user_w_write_8_open && r_open_d;
  assign w_rd_fall    = !user_r_read_32_open && r_rd_open_d;
  assign w_push_word  = w_flush_push ? pad_word(r_word, r_byte_idx)
                                     : put_lane(r_word, r_byte_idx, user_w_write_8_data);

  assign user_w_write_8_full  = w_full;
  assign user_r_read_32_data  = r_rdata;
  assign user_r_read_32_empty = w_empty;
  assign user_r_read_32_eof   = (r_state == DONE) && w_empty;
  assign fill_level           = r_fill;

  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) r_state <= IDLE;
    else            r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:  if (w_wr_rise) w_state_next = PACK;
      PACK:  if (w_wr_fall) w_state_next = (r_byte_idx != 2'd0) ? FLUSH : DONE;
      // A re-open seen while the partial word is still waiting resumes packing.
      FLUSH: if (w_flush_push) w_state_next = user_w_write_8_open ? PACK : DONE;
      DONE: begin
        if (w_wr_rise)                     w_state_next = PACK;
        else if (w_rd_fall && w_empty)     w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      r_open_d    <= 1'b0;
      r_rd_open_d <= 1'b0;
      r_byte_idx  <= 2'd0;
      r_word      <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_fill      <= '0;
      r_rdata     <= '0;
    end else begin
      r_open_d    <= user_w_write_8_open;
      r_rd_open_d <= user_r_read_32_open;
      if (w_flush_push)  r_byte_idx <= 2'd0;
      else if (w_accept) r_byte_idx <= r_byte_idx + 2'd1;
      if (w_push)        r_word <= '0;
      else if (w_accept) r_word <= put_lane(r_word, r_byte_idx, user_w_write_8_data);
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_rdata  <= r_mem[r_rd_ptr];
      end
      if (w_push && !w_pop)      r_fill <= r_fill + 1'b1;
      else if (!w_push && w_pop) r_fill <= r_fill - 1'b1;
    end
  end

  always_ff @(posedge bus_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_push_word;
  end

endmodule

// File: tb/tb_xillybus_stream_packer.sv
// Directed bench for xillybus_stream_packer: packing, flush/EOF, FIFO full, async reset and flush-into-full.
module tb_xillybus_stream_packer;

  logic        bus_clk = 1'b0;
  logic        bus_rst_n = 1'b0;
  logic        wren = 1'b0;
  logic [7:0]  wdata = 8'h00;
  logic        full;
  logic        wopen = 1'b0;
  logic        rden = 1'b0;
  logic [31:0] rdata;
  logic        empty;
  logic        eof;
  logic        ropen = 1'b0;
  logic [4:0]  fill;

  int checks = 0;
  int failures = 0;

  always #5 bus_clk = ~bus_clk;

  xillybus_stream_packer #(.DEPTH_LOG2(4), .PAD_BYTE(8'h00)) dut (
    .bus_clk              (bus_clk),
    .bus_rst_n            (bus_rst_n),
    .user_w_write_8_wren  (wren),
    .user_w_write_8_data  (wdata),
    .user_w_write_8_full  (full),
    .user_w_write_8_open  (wopen),
    .user_r_read_32_rden  (rden),
    .user_r_read_32_data  (rdata),
    .user_r_read_32_empty (empty),
    .user_r_read_32_eof   (eof),
    .user_r_read_32_open  (ropen),
    .fill_level           (fill)
  );

  function automatic logic [31:0] word4(input logic [7:0] b0, input logic [7:0] b1,
                                        input logic [7:0] b2, input logic [7:0] b3);
`ifdef XILLY_PACKER_BYTE_SWAP_EN
    return {b0, b1, b2, b3};
`else
    return {b3, b2, b1, b0};
`endif
  endfunction

  task automatic tick;
    @(posedge bus_clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] b);
    wren  = 1'b1;
    wdata = b;
    tick();
    wren  = 1'b0;
  endtask

  task automatic read_word;
    rden = 1'b1;
    tick();
    rden = 1'b0;
  endtask

  task automatic test_reset;
    tick();
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (eof !== 1'b0) begin failures++; $display("FAIL reset_eof got=%b exp=0", eof); end
    checks++; if (fill !== 5'd0) begin failures++; $display("FAIL reset_fill got=%0d exp=0", fill); end
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", rdata); end
    bus_rst_n = 1'b1;
    ropen = 1'b1;
    tick();
  endtask

  task automatic test_pack;
    wopen = 1'b1;
    tick();
    for (int i = 1; i <= 8; i++) write_byte(8'(i));
    checks++; if (fill !== 5'd2) begin failures++; $display("FAIL pack_fill got=%0d exp=2", fill); end
    read_word();
    checks++; if (rdata !== word4(8'h01, 8'h02, 8'h03, 8'h04)) begin
      failures++; $display("FAIL pack_word0 got=%h exp=%h", rdata, word4(8'h01, 8'h02, 8'h03, 8'h04)); end
    read_word();
    checks++; if (rdata !== word4(8'h05, 8'h06, 8'h07, 8'h08)) begin
      failures++; $display("FAIL pack_word1 got=%h exp=%h", rdata, word4(8'h05, 8'h06, 8'h07, 8'h08)); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL pack_empty got=%b exp=1", empty); end
    checks++; if (eof !== 1'b0) begin failures++; $display("FAIL pack_eof got=%b exp=0", eof); end
  endtask

  task automatic test_flush_eof;
    for (int i = 1; i <= 5; i++) write_byte(8'(i));
    wopen = 1'b0;
    tick();
    tick();
    checks++; if (fill !== 5'd2) begin failures++; $display("FAIL flush_fill got=%0d exp=2", fill); end
    read_word();
    checks++; if (rdata !== word4(8'h01, 8'h02, 8'h03, 8'h04)) begin
      failures++; $display("FAIL flush_word0 got=%h exp=%h", rdata, word4(8'h01, 8'h02, 8'h03, 8'h04)); end
    checks++; if (eof !== 1'b0) begin failures++; $display("FAIL flush_eof_early got=%b exp=0", eof); end
    read_word();
    checks++; if (rdata !== word4(8'h05, 8'h00, 8'h00, 8'h00)) begin
      failures++; $display("FAIL flush_partial got=%h exp=%h", rdata, word4(8'h05, 8'h00, 8'h00, 8'h00)); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL flush_empty got=%b exp=1", empty); end
    checks++; if (eof !== 1'b1) begin failures++; $display("FAIL flush_eof got=%b exp=1", eof); end
  endtask

  task automatic test_full;
    wopen = 1'b1;
    tick();
    checks++; if (eof !== 1'b0) begin failures++; $display("FAIL reopen_eof got=%b exp=0", eof); end
    for (int i = 0; i < 64; i++) write_byte(8'(i));
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL full_flag got=%b exp=1", full); end
    checks++; if (fill !== 5'd16) begin failures++; $display("FAIL full_fill got=%0d exp=16", fill); end
    write_byte(8'h99);
    checks++; if (fill !== 5'd16) begin failures++; $display("FAIL full_drop_fill got=%0d exp=16", fill); end
    read_word();
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL full_release got=%b exp=0", full); end
    checks++; if (fill !== 5'd15) begin failures++; $display("FAIL full_fill15 got=%0d exp=15", fill); end
    checks++; if (rdata !== word4(8'h00, 8'h01, 8'h02, 8'h03)) begin
      failures++; $display("FAIL full_first got=%h exp=%h", rdata, word4(8'h00, 8'h01, 8'h02, 8'h03)); end
    for (int w = 1; w < 16; w++) read_word();
    checks++; if (rdata !== word4(8'h3C, 8'h3D, 8'h3E, 8'h3F)) begin
      failures++; $display("FAIL full_last got=%h exp=%h", rdata, word4(8'h3C, 8'h3D, 8'h3E, 8'h3F)); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL full_drained got=%b exp=1", empty); end
    write_byte(8'h11); write_byte(8'h22); write_byte(8'h33); write_byte(8'h44);
    read_word();
    checks++; if (rdata !== word4(8'h11, 8'h22, 8'h33, 8'h44)) begin
      failures++; $display("FAIL full_dropped_byte got=%h exp=%h", rdata, word4(8'h11, 8'h22, 8'h33, 8'h44)); end
  endtask

  task automatic test_reset_mid;
    write_byte(8'h55);
    write_byte(8'h66);
    #4;
    bus_rst_n = 1'b0;
    wopen = 1'b0;
    #1;
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL arst_full got=%b exp=0", full); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL arst_empty got=%b exp=1", empty); end
    checks++; if (eof !== 1'b0) begin failures++; $display("FAIL arst_eof got=%b exp=0", eof); end
    checks++; if (fill !== 5'd0) begin failures++; $display("FAIL arst_fill got=%0d exp=0", fill); end
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL arst_data got=%h exp=0", rdata); end
    #2;
    bus_rst_n = 1'b1;
    tick();
    wopen = 1'b1;
    tick();
    write_byte(8'hAA); write_byte(8'hBB); write_byte(8'hCC); write_byte(8'hDD);
    checks++; if (fill !== 5'd1) begin failures++; $display("FAIL arst_refill got=%0d exp=1", fill); end
    read_word();
    checks++; if (rdata !== word4(8'hAA, 8'hBB, 8'hCC, 8'hDD)) begin
      failures++; $display("FAIL arst_word got=%h exp=%h", rdata, word4(8'hAA, 8'hBB, 8'hCC, 8'hDD)); end
  endtask

  task automatic test_flush_full;
    for (int i = 0; i < 60; i++) write_byte(8'(i));
    write_byte(8'hE0);
    write_byte(8'hE1);
    checks++; if (fill !== 5'd15) begin failures++; $display("FAIL ff_fill15 got=%0d exp=15", fill); end
    wopen = 1'b0;
    tick();
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL ff_flush_full got=%b exp=1", full); end
    tick();
    checks++; if (fill !== 5'd16) begin failures++; $display("FAIL ff_fill16 got=%0d exp=16", fill); end
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL ff_full16 got=%b exp=1", full); end
    checks++; if (eof !== 1'b0) begin failures++; $display("FAIL ff_eof_full got=%b exp=0", eof); end
    for (int w = 0; w < 15; w++) read_word();
    checks++; if (rdata !== word4(8'h38, 8'h39, 8'h3A, 8'h3B)) begin
      failures++; $display("FAIL ff_word14 got=%h exp=%h", rdata, word4(8'h38, 8'h39, 8'h3A, 8'h3B)); end
    checks++; if (eof !== 1'b0) begin failures++; $display("FAIL ff_eof_early got=%b exp=0", eof); end
    read_word();
    checks++; if (rdata !== word4(8'hE0, 8'hE1, 8'h00, 8'h00)) begin
      failures++; $display("FAIL ff_partial got=%h exp=%h", rdata, word4(8'hE0, 8'hE1, 8'h00, 8'h00)); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL ff_empty got=%b exp=1", empty); end
    checks++; if (eof !== 1'b1) begin failures++; $display("FAIL ff_eof got=%b exp=1", eof); end
    ropen = 1'b0;
    tick();
    checks++; if (eof !== 1'b0) begin failures++; $display("FAIL ff_rd_close_eof got=%b exp=0", eof); end
  endtask

  initial begin
    test_reset();
    test_pack();
    test_flush_eof();
    test_full();
    test_reset_mid();
    test_flush_full();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
